// File: rtl/div_alu_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer that borrows the EX-stage ALU for every subtract/compare.
// Optional DIV_EARLY_OUT_EN adds a PRECHK state that short-circuits |dividend| < |divisor|.
module div_alu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            alu_sel_o,
  output logic [XLEN-1:0] alu_operand_a_o,
  output logic [XLEN-1:0] alu_operand_b_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_NEG_N, S_NEG_D,
`ifdef DIV_EARLY_OUT_EN
    S_PRECHK,
`endif
    S_ITER_CMP, S_ITER_SUB, S_FIX_Q, S_FIX_R, S_DONE
  } state_t;

  localparam logic [3:0]      OP_SUB  = 4'h1;
  localparam logic [3:0]      OP_SLTU = 4'h3;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_EARLY_OUT_EN
  localparam state_t POST_NEG = S_PRECHK;
`else
  localparam state_t POST_NEG = S_ITER_CMP;
`endif

  state_t            state_q, state_d;
  logic [XLEN-1:0]   n_q, n_d, d_q, d_d, r_q, r_d, q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_n_q, neg_n_d, neg_d_q, neg_d_d, rem_q, rem_d;
  logic              rsp_valid_q, rsp_valid_d, busy_q, busy_d, req_ready_q, req_ready_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic [XLEN-1:0]   rs;
  logic              sgn;

  always_comb begin
    state_d = state_q;
    n_d = n_q; d_d = d_q; r_d = r_q; q_d = q_q; cnt_d = cnt_q;
    neg_n_d = neg_n_q; neg_d_d = neg_d_q; rem_d = rem_q;
    alu_sel_o = 1'b0; alu_operand_a_o = '0; alu_operand_b_o = '0; alu_op_o = 4'h0;
    rs  = {r_q[XLEN-2:0], n_q[cnt_q]};
    // Unlisted funct3 encodings fall back to plain DIVU.
    sgn = funct3_i[2] & ~funct3_i[0];

    case (state_q)
      S_IDLE: if (req_valid_i) begin
        n_d = rs1_i; d_d = rs2_i; r_d = '0; q_d = '0; cnt_d = '1;
        rem_d   = funct3_i[2] & funct3_i[1];
        neg_n_d = sgn & rs1_i[XLEN-1];
        neg_d_d = sgn & rs2_i[XLEN-1];
        if (rs2_i == '0) begin
          q_d = '1; r_d = rs1_i; state_d = S_DONE;
        end else if (sgn && rs1_i == INT_MIN && rs2_i == '1) begin
          q_d = INT_MIN; r_d = '0; state_d = S_DONE;
        end else begin
          state_d = neg_n_d ? S_NEG_N : (neg_d_d ? S_NEG_D : POST_NEG);
        end
      end
      S_NEG_N: begin
        alu_sel_o = 1'b1; alu_op_o = OP_SUB; alu_operand_b_o = n_q;
        n_d = alu_data_i;
        state_d = neg_d_q ? S_NEG_D : POST_NEG;
      end
      S_NEG_D: begin
        alu_sel_o = 1'b1; alu_op_o = OP_SUB; alu_operand_b_o = d_q;
        d_d = alu_data_i;
        state_d = POST_NEG;
      end
`ifdef DIV_EARLY_OUT_EN
      S_PRECHK: begin
        alu_sel_o = 1'b1; alu_op_o = OP_SLTU;
        alu_operand_a_o = n_q; alu_operand_b_o = d_q;
        if (alu_data_i[0]) begin
          q_d = '0; r_d = n_q; state_d = S_FIX_R;
        end else begin
          state_d = S_ITER_CMP;
        end
      end
`endif
      S_ITER_CMP: begin
        r_d = rs;
        // With the shifted-out bit set, Rs already exceeds any 32-bit divisor.
        if (r_q[XLEN-1]) begin
          state_d = S_ITER_SUB;
        end else begin
          alu_sel_o = 1'b1; alu_op_o = OP_SLTU;
          alu_operand_a_o = rs; alu_operand_b_o = d_q;
          if (alu_data_i[0]) begin
            q_d[cnt_q] = 1'b0;
            if (cnt_q == '0) state_d = S_FIX_Q;
            else begin cnt_d = cnt_q - 1'b1; state_d = S_ITER_CMP; end
          end else begin
            state_d = S_ITER_SUB;
          end
        end
      end
      S_ITER_SUB: begin
        alu_sel_o = 1'b1; alu_op_o = OP_SUB;
        alu_operand_a_o = r_q; alu_operand_b_o = d_q;
        r_d = alu_data_i;
        q_d[cnt_q] = 1'b1;
        if (cnt_q == '0) state_d = S_FIX_Q;
        else begin cnt_d = cnt_q - 1'b1; state_d = S_ITER_CMP; end
      end
      S_FIX_Q: begin
        if ((neg_n_q ^ neg_d_q) && !rem_q) begin
          alu_sel_o = 1'b1; alu_op_o = OP_SUB; alu_operand_b_o = q_q;
          q_d = alu_data_i;
        end
        state_d = (neg_n_q && rem_q) ? S_FIX_R : S_DONE;
      end
      S_FIX_R: begin
        if (neg_n_q && rem_q) begin
          alu_sel_o = 1'b1; alu_op_o = OP_SUB; alu_operand_b_o = r_q;
          r_d = alu_data_i;
        end
        state_d = S_DONE;
      end
      S_DONE: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (kill_i) state_d = S_IDLE;

    rsp_valid_d = (state_d == S_DONE);
    rsp_data_d  = (state_d == S_DONE) ? (rem_d ? r_d : q_d) : '0;
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      n_q <= '0; d_q <= '0; r_q <= '0; q_q <= '0; cnt_q <= '0;
      neg_n_q <= 1'b0; neg_d_q <= 1'b0; rem_q <= 1'b0;
      rsp_valid_q <= 1'b0; rsp_data_q <= '0; busy_q <= 1'b0; req_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q <= n_d; d_q <= d_d; r_q <= r_d; q_q <= q_d; cnt_q <= cnt_d;
      neg_n_q <= neg_n_d; neg_d_q <= neg_d_d; rem_q <= rem_d;
      rsp_valid_q <= rsp_valid_d; rsp_data_q <= rsp_data_d;
      busy_q <= busy_d; req_ready_q <= req_ready_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = busy_q;
  assign req_ready_o = req_ready_q;

endmodule

// File: tb/tb_div_alu_seq.sv
// Directed-vector bench for div_alu_seq with a behavioural model of the shared EX ALU.
module tb_div_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  funct3 = 3'd5;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        kill = 1'b0;
  logic        alu_sel;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready = 1'b0, busy;
  logic [31:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_y = (alu_op == 4'h1) ? alu_a - alu_b :
                 (alu_op == 4'h3) ? {31'd0, alu_a < alu_b} : 32'd0;

  div_alu_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
    .alu_sel_o(alu_sel), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_op_o(alu_op), .alu_data_i(alu_y),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issues one request, waits (bounded) for the response, optionally stalls
  // the consumer for `hold` cycles, then completes the handshake.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] res, output int lat,
                        output bit sel_seen, output bit bad);
    bad = 1'b0; sel_seen = 1'b0;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      if (alu_sel) begin
        sel_seen = 1'b1;
        if (alu_op != 4'h1 && alu_op != 4'h3) bad = 1'b1;
      end
      if (!busy) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = rsp_data;
    if (!busy || req_ready) bad = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== res || req_ready) bad = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, output int lat,
                       output bit sel_seen);
    logic [31:0] res;
    bit bad;
    run_op(f, a, b, 0, res, lat, sel_seen, bad);
    check({tag, "_timeout"}, 32'(lat >= 200), 32'd0);
    check({tag, "_data"}, res, exp);
    check({tag, "_alu_busy"}, 32'(bad), 32'd0);
    check({tag, "_idle_after"}, {30'd0, busy, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    bit sel;
    bit bad;
    logic [31:0] res;
    int seen;

    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_alu", {alu_sel, alu_op, 27'd0} | alu_a | alu_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, lat, sel);
    check("divu_lat_bound", 32'(lat >= 33 && lat <= 66), 32'd1);
    check("divu_alu_used", 32'(sel), 32'd1);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, lat, sel);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, lat, sel);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, lat, sel);
    check("rem_signed_lat", 32'(lat >= 33 && lat <= 68), 32'd1);
    do_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, sel);
    do_op("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, lat, sel);

    do_op("div_by0", 3'd4, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, lat, sel);
    check("div_by0_lat", lat, 32'd1);
    check("div_by0_nosel", 32'(sel), 32'd0);
    do_op("remu_by0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, lat, sel);
    check("remu_by0_nosel", 32'(sel), 32'd0);

    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat, sel);
    check("div_ovf_lat", lat, 32'd1);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, lat, sel);
    do_op("divu_max_1", 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, lat, sel);
    do_op("divu_max_max", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, lat, sel);
    do_op("funct3_other", 3'd0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, lat, sel);

    // Kill a long divide mid-flight; nothing from it may surface later.
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_valid", 32'(rsp_valid), 32'd0);
    check("kill_ready", 32'(req_ready), 32'd1);
    do_op("post_kill_divu", 3'd5, 32'd9, 32'd3, 32'd3, lat, sel);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("kill_no_stale", seen, 32'd0);

    // Kill coinciding with a request in IDLE blocks the accept.
    @(negedge clk);
    req_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("kill_req_busy", 32'(busy), 32'd0);

    run_op(3'd5, 32'd100, 32'd7, 5, res, lat, sel, bad);
    check("hold_data", res, 32'd14);
    check("hold_stable", 32'(bad), 32'd0);

    do_op("divu_5_9", 3'd5, 32'd5, 32'd9, 32'd0, lat, sel);
`ifdef DIV_EARLY_OUT_EN
    check("early_lat", 32'(lat <= 5), 32'd1);
`endif
    do_op("remu_5_9", 3'd7, 32'd5, 32'd9, 32'd5, lat, sel);
    do_op("rem_m5_9", 3'd6, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, lat, sel);

    // Asynchronous reset in the middle of an iteration.
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_alu_sel", {31'd0, alu_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst_divu", 3'd5, 32'd100, 32'd7, 32'd14, lat, sel);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
